// File: rtl/add32_seq.sv
// Sequential 32-bit adder: one shared 8-bit carry-lookahead slice, one byte per cycle, LSB first.
// Define ADD32_SEQ_SUB_EN to make the sub port select A - B; otherwise sub is ignored.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready=1
// RUN   | computing slice k (0..3), one byte per clock
// DONE  | result held on sum/cout/ovf; out_valid=1 until out_ready
module add32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [1:0]  k;
    logic        carry;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] sum_q;
    logic        cout_q;
    logic        ovf_q;
    logic        sub_eff;

`ifdef ADD32_SEQ_SUB_EN
    assign sub_eff = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_eff    = 1'b0;
`endif

    logic [7:0] sa;
    logic [7:0] sb;
    logic [7:0] sg;
    logic [7:0] sp;
    logic [7:0] ss;
    logic [8:0] sc;

    // Shared slice: b_q already holds the effective (possibly inverted) operand.
    always_comb begin
        sa    = a_q[{k, 3'b000} +: 8];
        sb    = b_q[{k, 3'b000} +: 8];
        sg    = sa & sb;
        sp    = sa ^ sb;
        sc    = '0;
        sc[0] = carry;
        for (int i = 0; i < 8; i++) begin
            sc[i+1] = sg[i] | (sp[i] & sc[i]);
        end
        ss = sp ^ sc[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= 2'd0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= sub_eff ? ~b : b;
                        carry <= sub_eff ? 1'b1 : cin;
                        k     <= 2'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[{k, 3'b000} +: 8] <= ss;
                    carry <= sc[8];
                    k     <= k + 2'd1;
                    if (k == 2'd3) begin
                        cout_q <= sc[8];
                        ovf_q  <= (sa[7] == sb[7]) && (ss[7] != sa[7]);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add32_seq.sv
// Self-checking bench for add32_seq: expected results queued at acceptance, popped when out_valid rises.
module tb_add32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [33:0] exp_q[$];

`ifdef ADD32_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    add32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: {ovf, cout, sum}
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mcin, input logic msub);
        logic [31:0] be;
        logic        ci;
        logic [32:0] r;
        logic        v;
        be = (msub && SUB_EN) ? ~mb : mb;
        ci = (msub && SUB_EN) ? 1'b1 : mcin;
        r  = {1'b0, ma} + {1'b0, be} + {32'd0, ci};
        v  = (ma[31] == be[31]) && (r[31] != ma[31]);
        return {v, r[32], r[31:0]};
    endfunction

    task automatic accept(input logic [31:0] ta, input logic [31:0] tb, input logic tcin, input logic tsub);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (sum !== 32'h0)       begin n_fail++; $display("FAIL reset_sum: got %h want 0", sum); end
        n_cmp++; if (cout !== 1'b0)       begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
        n_cmp++; if (ovf !== 1'b0)        begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_add_vectors();
        logic [31:0] va[3] = '{32'h0000_0005, 32'h7FFF_FFFF, 32'h00FF_FFFF};
        logic [31:0] vb[3] = '{32'hFFFF_FFFD, 32'h0000_0001, 32'h0000_0000};
        logic        vc[3] = '{1'b0, 1'b0, 1'b1};
        logic [33:0] ve[3] = '{{1'b0, 1'b1, 32'h0000_0002},
                               {1'b1, 1'b0, 32'h8000_0000},
                               {1'b0, 1'b0, 32'h0100_0000}};
        logic [33:0] e;
        int lat;
        for (int i = 0; i < 3; i++) begin
            accept(va[i], vb[i], vc[i], 1'b0);
            exp_q.push_back(ve[i]);
            wait_out(lat);
            e = exp_q.pop_front();
            n_cmp++; if (lat != 4)         begin n_fail++; $display("FAIL add%0d_latency: got %0d want 4", i, lat); end
            n_cmp++; if (sum !== e[31:0])  begin n_fail++; $display("FAIL add%0d_sum: got %h want %h", i, sum, e[31:0]); end
            n_cmp++; if (cout !== e[32])   begin n_fail++; $display("FAIL add%0d_cout: got %b want %b", i, cout, e[32]); end
            n_cmp++; if (ovf !== e[33])    begin n_fail++; $display("FAIL add%0d_ovf: got %b want %b", i, ovf, e[33]); end
            release_out();
        end
    endtask

    task automatic test_sub();
        logic [33:0] e;
        int lat;
        accept(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
`ifdef ADD32_SEQ_SUB_EN
        exp_q.push_back({1'b0, 1'b0, 32'hFFFF_FFFF});
`else
        exp_q.push_back({1'b0, 1'b0, 32'h0000_0001});
`endif
        wait_out(lat);
        e = exp_q.pop_front();
        n_cmp++; if (lat != 4)        begin n_fail++; $display("FAIL sub_latency: got %0d want 4", lat); end
        n_cmp++; if (sum !== e[31:0]) begin n_fail++; $display("FAIL sub_sum: got %h want %h", sum, e[31:0]); end
        n_cmp++; if (cout !== e[32])  begin n_fail++; $display("FAIL sub_cout: got %b want %b", cout, e[32]); end
        n_cmp++; if (ovf !== e[33])   begin n_fail++; $display("FAIL sub_ovf: got %b want %b", ovf, e[33]); end
        release_out();
    endtask

    task automatic test_hold();
        logic [33:0] e;
        int lat;
        int bad;
        accept(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 1'b1, 32'h0000_0000});
        wait_out(lat);
        e = exp_q.pop_front();
        n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL hold_latency: got %0d want 4", lat); end
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom;
            if ({ovf, cout, sum} !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_cycle%0d: got sum=%h cout=%b ovf=%b in_ready=%b out_valid=%b want sum=%h cout=%b ovf=%b in_ready=0 out_valid=1",
                         i, sum, cout, ovf, in_ready, out_valid, e[31:0], e[32], e[33]);
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (bad != 0) n_fail++;
        release_out();
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL hold_release_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_out_valid: got %b want 0", out_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [33:0] e;
        int lat;
        int seen;
        accept(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL midrst_stale_valid: got %0d valid cycles want 0", seen); end
        accept(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 32'h0000_0002});
        wait_out(lat);
        e = exp_q.pop_front();
        n_cmp++; if (lat != 4)        begin n_fail++; $display("FAIL midrst_latency: got %0d want 4", lat); end
        n_cmp++; if (sum !== e[31:0]) begin n_fail++; $display("FAIL midrst_sum: got %h want %h", sum, e[31:0]); end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [33:0] e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic        rs;
        int lat;
        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h0000_0000; rc = 1'b1; rs = 1'b0; end
            accept(ra, rb, rc, rs);
            exp_q.push_back(model(ra, rb, rc, rs));
            wait_out(lat);
            e = exp_q.pop_front();
            n_cmp++; if (lat != 4)        begin n_fail++; $display("FAIL b2b%0d_latency: got %0d want 4", i, lat); end
            n_cmp++; if (sum !== e[31:0]) begin n_fail++; $display("FAIL b2b%0d_sum: got %h want %h (a=%h b=%h cin=%b sub=%b)", i, sum, e[31:0], ra, rb, rc, rs); end
            n_cmp++; if (cout !== e[32])  begin n_fail++; $display("FAIL b2b%0d_cout: got %b want %b", i, cout, e[32]); end
            n_cmp++; if (ovf !== e[33])   begin n_fail++; $display("FAIL b2b%0d_ovf: got %b want %b", i, ovf, e[33]); end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_add_vectors();
        test_sub();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/add32_seq.md
ADD32_SEQ -- requirements
Module: add32_seq

Interface
REQ-001: Parameters SHALL be none; the slice width is fixed at 8 bits and the operand width at 32 bits.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004: in_valid  input  1  requester presents an operation.
REQ-005: in_ready  output  1  block accepts an operation this cycle.
REQ-006: a  input  32  operand A.
REQ-007: b  input  32  operand B.
REQ-008: cin  input  1  carry-in for add.
REQ-009: sub  input  1  1 = A - B (effective only with ADD32_SEQ_SUB_EN).
REQ-010: out_valid  output  1  result is available.
REQ-011: out_ready  input  1  consumer takes the result.
REQ-012: sum  output  32  result.
REQ-013: cout  output  1  carry out of bit 31.
REQ-014: ovf  output  1  signed two's-complement overflow.

Function
REQ-015: The block SHALL compute the 32-bit result with a single shared 8-bit carry-lookahead slice over 4 cycles, least significant byte first.
REQ-016: The FSM SHALL have states IDLE, RUN and DONE, plus a 2-bit slice counter k (0..3).
REQ-017: in_ready SHALL equal 1 only in IDLE; out_valid SHALL equal 1 only in DONE; both SHALL be decoded combinationally from state.
REQ-018: IDLE -> RUN SHALL occur on an edge with in_valid=1; that edge SHALL capture a, b, cin and sub, set k=0, and load the carry register.
REQ-019: In RUN, each edge SHALL compute slice k: write byte sum[8k+7:8k], store the slice carry-out as the next carry-in, and increment k.
REQ-020: RUN -> DONE SHALL occur on the edge that completes k=3, so out_valid rises exactly 4 cycles after the accepting edge.
REQ-021: The effective carry-in of slice 0 SHALL be cin for add, and 1 for sub (cin ignored); the effective B SHALL be ~b for sub.
REQ-022: cout SHALL be the carry out of slice 3.
REQ-023: ovf SHALL be set when the effective operand sign bits are equal and differ from sum[31].
REQ-024: DONE SHALL hold sum, cout and ovf stable while out_ready=0.
REQ-025: DONE -> IDLE SHALL occur on an edge with out_ready=1; no new operation SHALL be accepted in that same cycle.
REQ-026: Changes on a, b, cin or sub after the accepting edge SHALL NOT affect the result.
REQ-027: in_valid during RUN or DONE SHALL be ignored; it is not queued.

Reset
REQ-028: On rst=1 the block SHALL enter IDLE with k=0, carry register 0, sum=0, cout=0, ovf=0, out_valid=0 and in_ready=1 after the edge.
REQ-029: rst SHALL take priority over all handshakes; reset mid-RUN or in DONE SHALL discard the operation, and out_valid SHALL NOT assert for it.

Configuration
REQ-030: With macro ADD32_SEQ_SUB_EN defined, sub SHALL select subtraction as in REQ-021.
REQ-031: Without ADD32_SEQ_SUB_EN, the sub port SHALL remain present but be ignored, and every operation SHALL be an add with cin.

Verification
REQ-032: Add, a=0x00000005, b=0xFFFFFFFD, cin=0 -> sum=0x00000002, cout=1, ovf=0, with out_valid exactly 4 cycles after acceptance.
REQ-033: Add, a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-034: Add, a=0x00FFFFFF, b=0x00000000, cin=1 -> sum=0x01000000, cout=0, ovf=0; this checks carry propagation across slices 0-2.
REQ-035: With SUB_EN, sub=1, a=0x00000000, b=0x00000001 -> sum=0xFFFFFFFF, cout=0, ovf=0; without SUB_EN, the same stimulus -> sum=0x00000001.
REQ-036: Hold out_ready=0 for 10 cycles in DONE -> sum, cout and ovf stay constant and in_ready stays 0; then assert out_ready for 1 cycle -> in_ready=1 on the next cycle.
REQ-037: Assert rst for 1 cycle while k=2 -> out_valid stays 0 and in_ready=1 on the next cycle; a following add 1+1 -> sum=0x00000002.
